ranc_tick_scheduler: RTL and testbench
======================================

Name: ranc_tick_scheduler

Overview:
- Sequences a RANC network grid through a run of NUM_RUN_TICKS ticks.
- For each tick it accepts that tick's input spike packets from a host stream and presents them to the grid's west input port (core 0) as a single-entry input buffer.
- After the grid drains the buffer it waits a settle window and enforces a minimum tick period, then pulses tick.
- Grid error flags are monitored and the run aborts on any error.

Parameters:
PACKET_WIDTH, 30, width of a grid input packet (dx+dy+axon+tick fields)
NUM_RUN_TICKS, 16, ticks issued per run (>=1)
SETTLE_CYCLES, 64, cycles waited after the buffer drains before tick (>=1)
MIN_TICK_PERIOD, 256, minimum cycles between consecutive tick pulses (>=2)
DRAIN_TIMEOUT, 1024, max cycles allowed in DRAIN before a timeout error

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active high
start  input  1  one-cycle pulse; begins a run when in IDLE or DONE
host_valid  input  1  host packet valid
host_packet  input  PACKET_WIDTH  host packet
host_last  input  1  qualifies host_valid; marks the last packet of the current tick
host_skip  input  1  in LOAD with host_valid=0: ends the load phase with no (more) packets
host_ready  output  1  packet accepted when host_valid&host_ready
grid_packet  output  PACKET_WIDTH  to grid packet_in
grid_input_empty  output  1  to grid input_buffer_empty
grid_ren  input  1  from grid ren_to_input_buffer
grid_tc_error  input  1  grid token_controller_error
grid_sch_error  input  1  grid scheduler_error
tick  output  1  one-cycle tick pulse to grid
tick_count  output  $clog2(NUM_RUN_TICKS+1)  ticks issued this run
busy  output  1  state is not IDLE or DONE
done  output  1  high while in DONE
error  output  1  sticky error; cleared by rst or start
timeout  output  1  sticky; error cause was a drain timeout

Behaviour:
- Reset: state=IDLE; all counters 0; holding register empty; all outputs 0 except grid_input_empty=1; grid_packet=0.
- Holding register (held_valid, held_pkt):
  - grid_input_empty = !held_valid; grid_packet = held_pkt.
  - grid_ren while held_valid clears held_valid next cycle. grid_ren while empty is ignored.
  - host_ready = (state==LOAD) && (!held_valid || grid_ren). Back-to-back packets run at 1/cycle.
  - A simultaneous ren and load leaves held_valid=1 holding the new packet.
- FSM states:
  - IDLE: on start -> LOAD. tick_count=0, error=0, timeout=0, period counter preset to MIN_TICK_PERIOD.
  - LOAD:
    - Accepting a packet with host_last=1 -> DRAIN.
    - host_skip with host_valid=0 -> DRAIN.
    - host_valid has priority over host_skip.
  - DRAIN:
    - held_valid==0 -> SETTLE; settle counter loaded with SETTLE_CYCLES.
    - Drain counter reaching DRAIN_TIMEOUT -> DONE with error=1, timeout=1.
  - SETTLE:
    - Decrement the settle counter.
    - When the settle counter is 0 and the period counter >= MIN_TICK_PERIOD -> TICK.
  - TICK:
    - tick=1 for exactly this cycle; tick_count+1; period counter reset to 1.
    - Then -> DONE if the new tick_count==NUM_RUN_TICKS, else -> LOAD.
  - DONE: done=1; start -> LOAD with the same re-initialisation as from IDLE.
- Period counter increments every cycle, saturating at MIN_TICK_PERIOD. The first tick of a run is not period-limited.
- Errors:
  - grid_tc_error or grid_sch_error high in any busy state sets error the next cycle and forces -> DONE.
  - No tick is issued in or after that cycle; an abort and a tick are never both issued in the same cycle.
  - The holding register is flushed on abort.
- start while busy is ignored. rst mid-run returns to the reset values on the next edge, discarding the held packet.
- Tick-to-tick latency with no packets: max(1+1+SETTLE_CYCLES+1, MIN_TICK_PERIOD).

Test Plan:
- Reset, start, 3 packets with the last flagged, grid_ren asserted 2 cycles after each empty=0, SETTLE=4, MIN_TICK_PERIOD=2 -> 3 packets appear in order, exactly one tick pulse 4+ cycles after the final ren, tick_count=1.
- grid_ren held high with host_valid streaming 8 packets -> host_ready stays high, one packet consumed per cycle, no drop or duplicate.
- NUM_RUN_TICKS=4, host_skip each tick, SETTLE=4, MIN_TICK_PERIOD=20 -> exactly 4 ticks spaced 20 cycles apart, then done=1, tick_count=4.
- grid_ren tied low after one packet, DRAIN_TIMEOUT=16 -> DONE 16 cycles after entering DRAIN, error=1, timeout=1, no tick.
- grid_sch_error pulsed in the same cycle SETTLE would enter TICK -> no tick pulse, error=1, done=1; a later start clears error and the run restarts with tick_count=0.
- rst asserted while held_valid=1 in LOAD -> next cycle grid_input_empty=1, state IDLE, tick_count=0.

Source files
------------

// File: rtl/ranc_tick_scheduler_if.sv
// Host packet stream and grid input-port signals of the RANC tick scheduler.
// slave = scheduler side, master = host/grid environment side.
interface ranc_tick_scheduler_if #(
  parameter int PACKET_WIDTH = 30
);
  logic                    host_valid;
  logic [PACKET_WIDTH-1:0] host_packet;
  logic                    host_last;
  logic                    host_skip;
  logic                    host_ready;
  logic [PACKET_WIDTH-1:0] grid_packet;
  logic                    grid_input_empty;
  logic                    grid_ren;
  logic                    grid_tc_error;
  logic                    grid_sch_error;
  logic                    tick;

  modport slave (
    input  host_valid, host_packet, host_last, host_skip,
    input  grid_ren, grid_tc_error, grid_sch_error,
    output host_ready, grid_packet, grid_input_empty, tick
  );

  modport master (
    output host_valid, host_packet, host_last, host_skip,
    output grid_ren, grid_tc_error, grid_sch_error,
    input  host_ready, grid_packet, grid_input_empty, tick
  );
endinterface

// File: rtl/ranc_tick_scheduler.sv
// Runs a RANC grid through NUM_RUN_TICKS ticks: loads each tick's host packets
// through a single-entry buffer, waits for drain + settle + min period, pulses tick.
module ranc_tick_scheduler #(
  parameter int PACKET_WIDTH    = 30,
  parameter int NUM_RUN_TICKS   = 16,
  parameter int SETTLE_CYCLES   = 64,
  parameter int MIN_TICK_PERIOD = 256,
  parameter int DRAIN_TIMEOUT   = 1024,
  localparam int TCW            = $clog2(NUM_RUN_TICKS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  ranc_tick_scheduler_if.slave bus,
  output logic [TCW-1:0]       tick_count,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 timeout
);

  localparam int PERW = $clog2(MIN_TICK_PERIOD + 1);
  localparam int SW   = $clog2(SETTLE_CYCLES + 1);
  localparam int DW   = $clog2(DRAIN_TIMEOUT + 1);

  localparam logic [TCW-1:0]  NUM_T        = TCW'(NUM_RUN_TICKS);
  localparam logic [PERW-1:0] MIN_P        = PERW'(MIN_TICK_PERIOD);
  localparam logic [PERW-1:0] PERIOD_READY = PERW'(MIN_TICK_PERIOD - 1);
  localparam logic [SW-1:0]   SETTLE_C     = SW'(SETTLE_CYCLES);
  localparam logic [DW-1:0]   DRAIN_T      = DW'(DRAIN_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_SETTLE,
    S_TICK,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    held_valid_q, held_valid_d;
  logic [PACKET_WIDTH-1:0] held_pkt_q, held_pkt_d;
  logic [TCW-1:0]          tick_count_q, tick_count_d;
  logic [PERW-1:0]         period_q, period_d;
  logic [SW-1:0]           settle_q, settle_d;
  logic [DW-1:0]           drain_q, drain_d;
  logic                    error_q, error_d;
  logic                    timeout_q, timeout_d;

  logic grid_err;
  logic in_busy;
  logic abort;
  logic host_ready;
  logic accept;
  logic tick_o;

  assign grid_err   = bus.grid_tc_error | bus.grid_sch_error;
  assign in_busy    = state_q inside {S_LOAD, S_DRAIN, S_SETTLE, S_TICK};
  assign abort      = in_busy && grid_err;
  assign host_ready = (state_q == S_LOAD) && (!held_valid_q || bus.grid_ren);
  assign accept     = bus.host_valid && host_ready;

  always_comb begin
    state_d      = state_q;
    held_valid_d = held_valid_q;
    held_pkt_d   = held_pkt_q;
    tick_count_d = tick_count_q;
    period_d     = (period_q >= MIN_P) ? MIN_P : period_q + PERW'(1);
    settle_d     = settle_q;
    drain_d      = '0;
    error_d      = error_q;
    timeout_d    = timeout_q;
    tick_o       = 1'b0;

    if (bus.grid_ren && held_valid_q) held_valid_d = 1'b0;
    if (accept) begin
      held_valid_d = 1'b1;
      held_pkt_d   = bus.host_packet;
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_LOAD;
          tick_count_d = '0;
          error_d      = 1'b0;
          timeout_d    = 1'b0;
          period_d     = MIN_P;
        end
      end
      S_LOAD: begin
        if (accept && bus.host_last) state_d = S_DRAIN;
        else if (!bus.host_valid && bus.host_skip) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        drain_d = drain_q + DW'(1);
        if (!held_valid_q) begin
          state_d  = S_SETTLE;
          settle_d = SETTLE_C;
        end else if (drain_q + DW'(1) == DRAIN_T) begin
          state_d      = S_DONE;
          error_d      = 1'b1;
          timeout_d    = 1'b1;
          held_valid_d = 1'b0;
        end
      end
      S_SETTLE: begin
        settle_d = (settle_q == '0) ? '0 : settle_q - SW'(1);
        // Decision is made one cycle ahead of TICK, so both counters are
        // checked one count early to land the tick exactly on the boundary.
        if (settle_q <= SW'(1) && period_q >= PERIOD_READY) state_d = S_TICK;
      end
      S_TICK: begin
        tick_o       = 1'b1;
        tick_count_d = tick_count_q + TCW'(1);
        period_d     = PERW'(1);
        state_d      = (tick_count_q + TCW'(1) == NUM_T) ? S_DONE : S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d      = S_DONE;
      error_d      = 1'b1;
      held_valid_d = 1'b0;
      tick_o       = 1'b0;
      tick_count_d = tick_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      held_valid_q <= 1'b0;
      held_pkt_q   <= '0;
      tick_count_q <= '0;
      period_q     <= '0;
      settle_q     <= '0;
      drain_q      <= '0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_valid_q <= held_valid_d;
      held_pkt_q   <= held_pkt_d;
      tick_count_q <= tick_count_d;
      period_q     <= period_d;
      settle_q     <= settle_d;
      drain_q      <= drain_d;
      error_q      <= error_d;
      timeout_q    <= timeout_d;
    end
  end

  assign bus.host_ready       = host_ready;
  assign bus.grid_packet      = held_pkt_q;
  assign bus.grid_input_empty = !held_valid_q;
  assign bus.tick             = tick_o;
  assign tick_count           = tick_count_q;
  assign busy                 = in_busy;
  assign done                 = (state_q == S_DONE);
  assign error                = error_q;
  assign timeout              = timeout_q;

endmodule

// File: tb/tb_ranc_tick_scheduler.sv
// Directed bench for ranc_tick_scheduler: packet ordering via a scoreboard queue,
// tick timing, run completion, drain timeout, grid error abort and mid-run reset.
module tb_ranc_tick_scheduler;
  localparam int PW     = 30;
  localparam int NUM    = 4;
  localparam int SETTLE = 4;
  localparam int MINP   = 20;
  localparam int DT     = 16;
  localparam int TCW    = $clog2(NUM + 1);

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [TCW-1:0] tick_count;
  logic           busy, done, error, timeout;

  ranc_tick_scheduler_if #(.PACKET_WIDTH(PW)) bus ();

  ranc_tick_scheduler #(
    .PACKET_WIDTH(PW),
    .NUM_RUN_TICKS(NUM),
    .SETTLE_CYCLES(SETTLE),
    .MIN_TICK_PERIOD(MINP),
    .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus),
    .tick_count(tick_count),
    .busy(busy),
    .done(done),
    .error(error),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nticks = 0;
  int last_tick = -1;
  bit acc, cons;
  logic [PW-1:0] sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven at the falling edge; this samples just after, then clocks.
  task automatic step();
    logic [PW-1:0] e;
    #1;
    acc  = bus.host_valid && bus.host_ready;
    cons = bus.grid_ren && !bus.grid_input_empty;
    if (cons) begin
      e = (sb.size() > 0) ? sb.pop_front() : 'x;
      chk("grid_pkt", 64'(bus.grid_packet), 64'(e));
    end
    if (acc) sb.push_back(bus.host_packet);
    if (bus.tick === 1'b1) begin
      nticks++;
      last_tick = cyc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_in();
    start              = 1'b0;
    bus.host_valid     = 1'b0;
    bus.host_packet    = '0;
    bus.host_last      = 1'b0;
    bus.host_skip      = 1'b0;
    bus.grid_ren       = 1'b0;
    bus.grid_tc_error  = 1'b0;
    bus.grid_sch_error = 1'b0;
  endtask

  task automatic wait_tick(input int limit, output int when);
    int n0;
    n0 = nticks;
    for (int i = 0; i < limit && nticks == n0; i++) step();
    chk("tick_within_budget", nticks - n0, 1);
    when = last_tick;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, required finish before 1000000");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] pk[3];
    int idx, age, n0, last_ren, ncons, t_prev, w, s, a;
    bit prev_empty, last_cons, v;

    clear_in();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_tick_count", tick_count, 0);
    chk("rst_empty", bus.grid_input_empty, 1);
    chk("rst_grid_packet", bus.grid_packet, 0);
    chk("rst_host_ready", bus.host_ready, 0);
    chk("rst_tick", bus.tick, 0);

    // Three packets, grid reads each two cycles after it appears.
    pk[0] = 30'h0ABC_DEF1;
    pk[1] = 30'h3FFF_FFFF;
    pk[2] = 30'h1555_0AA0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy_after_start", busy, 1);
    idx = 0; age = 0; prev_empty = 1'b1; last_cons = 1'b0; last_ren = -1;
    n0 = nticks;
    for (int i = 0; i < 80 && nticks == n0; i++) begin
      if (!bus.grid_input_empty && (prev_empty || last_cons)) age = 0;
      else if (!bus.grid_input_empty) age++;
      bus.host_valid  = (idx < 3);
      bus.host_packet = (idx < 3) ? pk[idx] : '0;
      bus.host_last   = (idx == 2);
      bus.grid_ren    = !bus.grid_input_empty && (age == 2);
      prev_empty      = bus.grid_input_empty;
      step();
      if (acc) idx++;
      last_cons = cons;
      if (cons) last_ren = cyc - 1;
    end
    clear_in();
    chk("t1_accepted", idx, 3);
    chk("t1_ticks", nticks - n0, 1);
    chk("t1_tick_after_last_ren", last_tick - last_ren, SETTLE + 2);
    chk("t1_tick_count", tick_count, 1);
    chk("t1_sb_empty", sb.size(), 0);

    // Streaming: ren held high, eight packets back to back.
    idx = 0; ncons = 0;
    n0 = nticks;
    bus.grid_ren = 1'b1;
    for (int i = 0; i < 60 && nticks == n0; i++) begin
      v = (idx < 8);
      bus.host_valid  = v;
      bus.host_packet = PW'($urandom);
      bus.host_last   = (idx == 7);
      step();
      if (v) chk("t2_ready_streaming", acc, 1);
      if (acc) idx++;
      if (cons) ncons++;
    end
    clear_in();
    chk("t2_accepted", idx, 8);
    chk("t2_consumed", ncons, 8);
    chk("t2_sb_empty", sb.size(), 0);
    chk("t2_tick_count", tick_count, 2);
    t_prev = last_tick;

    // Remaining ticks of the run by skipping: period-limited spacing.
    bus.host_skip = 1'b1;
    for (int k = 3; k <= NUM; k++) begin
      wait_tick(40, w);
      chk("t3_spacing", w - t_prev, MINP);
      t_prev = w;
    end
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    chk("t3_tick_count", tick_count, NUM);
    n0 = nticks;
    repeat (25) step();
    chk("t3_no_tick_in_done", nticks - n0, 0);

    // Second run, all skips: first tick not period-limited.
    start = 1'b1;
    step();
    s = cyc - 1;
    start = 1'b0;
    chk("r2_tick_count_cleared", tick_count, 0);
    wait_tick(20, w);
    chk("r2_first_tick_latency", w - s, SETTLE + 3);
    for (int k = 2; k <= NUM; k++) begin
      t_prev = w;
      wait_tick(40, w);
      chk("r2_spacing", w - t_prev, MINP);
    end
    chk("r2_done", done, 1);
    chk("r2_tick_count", tick_count, NUM);

    // Drain timeout: one packet, grid never reads it.
    clear_in();
    start = 1'b1;
    step();
    start = 1'b0;
    bus.host_valid  = 1'b1;
    bus.host_packet = 30'h2468_ACE1;
    bus.host_last   = 1'b1;
    step();
    a = cyc - 1;
    chk("t4_accept", acc, 1);
    clear_in();
    n0 = nticks;
    for (int i = 0; i < 40 && !done; i++) step();
    chk("t4_done_cycle", cyc - a, DT + 1);
    chk("t4_error", error, 1);
    chk("t4_timeout", timeout, 1);
    chk("t4_no_tick", nticks - n0, 0);
    chk("t4_busy", busy, 0);
    sb.delete();

    // Scheduler error exactly when SETTLE would move to TICK.
    bus.host_skip = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_error_cleared", error, 0);
    chk("t5_timeout_cleared", timeout, 0);
    chk("t5_tick_count_cleared", tick_count, 0);
    n0 = nticks;
    repeat (5) step();
    chk("t5_busy_before_err", busy, 1);
    bus.grid_sch_error = 1'b1;
    step();
    bus.grid_sch_error = 1'b0;
    chk("t5_done", done, 1);
    chk("t5_error", error, 1);
    chk("t5_timeout", timeout, 0);
    chk("t5_tick_count", tick_count, 0);
    repeat (10) step();
    chk("t5_no_tick", nticks - n0, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5_restart_error", error, 0);
    chk("t5_restart_tick_count", tick_count, 0);
    chk("t5_restart_busy", busy, 1);
    wait_tick(20, w);
    chk("t5_restart_tick_count_1", tick_count, 1);

    // Reset while a packet sits in the holding register.
    clear_in();
    bus.host_valid  = 1'b1;
    bus.host_packet = 30'h0F0F_0F0F;
    step();
    chk("t6_accept", acc, 1);
    bus.host_valid = 1'b0;
    chk("t6_held", bus.grid_input_empty, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_empty", bus.grid_input_empty, 1);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_tick_count", tick_count, 0);
    sb.delete();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
